// File: rtl/proc_pkg.sv
// Shared definitions for the processor control FSM.
// Holds the instruction opcodes, the control step encoding and the ALU
// operation codes, plus small decode helpers used by proc_control.
package proc_pkg;

   // Instruction opcodes, ir[8:6]
   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_MVNZ = 3'b110;
   localparam logic [2:0] OP_NOP  = 3'b111;

   // ALU operation codes driven on alu_op
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   // Control steps; T0 is fetch/idle
   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   // True for the opcodes that go through A/G and take four steps
   function automatic logic is_alu_op(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

   // ALU function for an ALU opcode; ADD for anything else
   function automatic logic [1:0] alu_code(input logic [2:0] op);
      logic [1:0] code;
      case (op)
         OP_SUB:  code = ALU_SUB;
         OP_AND:  code = ALU_AND;
         OP_OR:   code = ALU_OR;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable.
// Ports:
//   sel  - binary register index
//   en   - when 0 the output is all zeros
//   y    - one-hot output, y[sel] = en
module dec3to8 (
   input  logic [2:0] sel,
   input  logic       en,
   output logic [7:0] y
);

   always_comb begin
      y = '0;
      if (en) begin
         y[sel] = 1'b1;
      end
   end

endmodule

// File: rtl/proc_control.sv
// Control FSM for the 16-bit bus-based processor datapath.
// Steps one instruction at a time through T0..T3, generating the shared bus
// source selects and the register load enables as a combinational decode of
// the current step and ir.
// Ports:
//   clock, reset        - rising-edge clock, async active-high reset
//   run                 - start request, examined only in T0
//   ir                  - opcode [8:6], rx [5:3], ry [2:0]
//   g_nz                - G register non-zero, qualifies mvnz
//   r_out, din_out, g_out - bus source selects (at most one high)
//   r_in, ir_in, a_in, g_in - load enables
//   alu_op              - ALU function, valid in T2, 00 otherwise
//   done                - last step of an instruction
module proc_control #(
   parameter bit ENABLE_MVNZ = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       run,
   input  logic [8:0] ir,
   input  logic       g_nz,
   output logic [7:0] r_out,
   output logic       din_out,
   output logic       g_out,
   output logic [7:0] r_in,
   output logic       ir_in,
   output logic       a_in,
   output logic       g_in,
   output logic [1:0] alu_op,
   output logic       done
);

   import proc_pkg::*;

   state_t     state_q, state_d;
   logic [2:0] opcode, rx, ry;
   logic [2:0] r_out_sel;
   logic       r_out_en;
   logic       r_in_en;

   assign opcode = ir[8:6];
   assign rx     = ir[5:3];
   assign ry     = ir[2:0];

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= T0;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         T0: state_d = run ? T1 : T0;
         T1: state_d = is_alu_op(opcode) ? T2 : T0;
         T2: state_d = T3;
         T3: state_d = T0;
         default: state_d = T0;
      endcase
   end

   // Output decode. Gated by reset so nothing is enabled while reset is high,
   // even though T0 with run=1 would otherwise assert ir_in.
   always_comb begin
      r_out_sel = ry;
      r_out_en  = 1'b0;
      r_in_en   = 1'b0;
      din_out   = 1'b0;
      g_out     = 1'b0;
      ir_in     = 1'b0;
      a_in      = 1'b0;
      g_in      = 1'b0;
      alu_op    = ALU_ADD;
      done      = 1'b0;
      if (!reset) begin
         unique case (state_q)
            T0: ir_in = run;
            T1: begin
               case (opcode)
                  OP_MV: begin
                     r_out_en = 1'b1;
                     r_in_en  = 1'b1;
                     done     = 1'b1;
                  end
                  OP_MVI: begin
                     din_out = 1'b1;
                     r_in_en = 1'b1;
                     done    = 1'b1;
                  end
                  OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                     r_out_sel = rx;
                     r_out_en  = 1'b1;
                     a_in      = 1'b1;
                  end
                  OP_MVNZ: begin
                     // Without mvnz support this falls back to a nop
                     if (ENABLE_MVNZ && g_nz) begin
                        r_out_en = 1'b1;
                        r_in_en  = 1'b1;
                     end
                     done = 1'b1;
                  end
                  default: done = 1'b1;
               endcase
            end
            T2: begin
               r_out_en = 1'b1;
               g_in     = 1'b1;
               alu_op   = alu_code(opcode);
            end
            T3: begin
               g_out   = 1'b1;
               r_in_en = 1'b1;
               done    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Register-field decode: r_out picks rx or ry, r_in always targets rx
   dec3to8 u_dec_r_out (
      .sel (r_out_sel),
      .en  (r_out_en),
      .y   (r_out)
   );

   dec3to8 u_dec_r_in (
      .sel (rx),
      .en  (r_in_en),
      .y   (r_in)
   );

endmodule

// File: tb/tb_proc_control.sv
module tb_proc_control;

   localparam bit MVNZ_EN = 1'b1;

   logic       clock = 1'b0;
   logic       reset;
   logic       run;
   logic [8:0] ir;
   logic       g_nz;
   logic [7:0] r_out, r_in;
   logic       din_out, g_out, ir_in, a_in, g_in, done;
   logic [1:0] alu_op;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   proc_control #(.ENABLE_MVNZ(MVNZ_EN)) dut (
      .clock   (clock),
      .reset   (reset),
      .run     (run),
      .ir      (ir),
      .g_nz    (g_nz),
      .r_out   (r_out),
      .din_out (din_out),
      .g_out   (g_out),
      .r_in    (r_in),
      .ir_in   (ir_in),
      .a_in    (a_in),
      .g_in    (g_in),
      .alu_op  (alu_op),
      .done    (done)
   );

   typedef struct packed {
      logic [7:0] r_out;
      logic       din_out;
      logic       g_out;
      logic [7:0] r_in;
      logic       ir_in;
      logic       a_in;
      logic       g_in;
      logic [1:0] alu_op;
      logic       done;
   } outs_t;

   typedef struct {
      string      name;
      logic       run;
      logic [8:0] ir;
      logic       g_nz;
      outs_t      exp;
   } vec_t;

   outs_t act;
   assign act = '{r_out, din_out, g_out, r_in, ir_in, a_in, g_in, alu_op, done};

   function automatic outs_t o(input logic [7:0] ro, input logic din, input logic go,
                               input logic [7:0] ri, input logic iri, input logic ai,
                               input logic gi, input logic [1:0] alu, input logic dn);
      outs_t r;
      r = '{ro, din, go, ri, iri, ai, gi, alu, dn};
      return r;
   endfunction

   task automatic check(input string name, input outs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus select must never have more than one driver
   always @(negedge clock) begin
      checks++;
      if ($countones({r_out, din_out, g_out}) > 1) begin
         errors++;
         $display("FAIL bus_onehot: r_out=%h din_out=%b g_out=%b", r_out, din_out, g_out);
      end
   end

   // Drive after a rising edge, sample on the following falling edge
   task automatic step(input logic r, input logic [8:0] i, input logic g);
      @(posedge clock);
      #1;
      run  = r;
      ir   = i;
      g_nz = g;
      @(negedge clock);
   endtask

   // Reference model: expected outputs for step k of an instruction
   function automatic outs_t model(input int k, input logic r, input logic [8:0] i,
                                   input logic g);
      outs_t e;
      logic [2:0] op, x, y;
      op = i[8:6];
      x  = i[5:3];
      y  = i[2:0];
      e  = '0;
      if (k == 0) begin
         e.ir_in = r;
      end else if (k == 1) begin
         if (op == 3'd0) begin
            e.r_out = 8'b1 << y; e.r_in = 8'b1 << x; e.done = 1'b1;
         end else if (op == 3'd1) begin
            e.din_out = 1'b1; e.r_in = 8'b1 << x; e.done = 1'b1;
         end else if (op >= 3'd2 && op <= 3'd5) begin
            e.r_out = 8'b1 << x; e.a_in = 1'b1;
         end else begin
            if (op == 3'd6 && MVNZ_EN && g) begin
               e.r_out = 8'b1 << y; e.r_in = 8'b1 << x;
            end
            e.done = 1'b1;
         end
      end else if (k == 2) begin
         e.r_out = 8'b1 << y; e.g_in = 1'b1; e.alu_op = 2'(op - 3'd2);
      end else begin
         e.g_out = 1'b1; e.r_in = 8'b1 << x; e.done = 1'b1;
      end
      return e;
   endfunction

   vec_t vecs[$];

   initial begin
      outs_t z;
      z = '0;

      reset = 1'b1;
      run   = 1'b1;
      ir    = 9'b001_010_000;
      g_nz  = 1'b0;
      #2;
      check("reset_outputs_run1", z);
      @(negedge clock);
      check("reset_held", z);
      @(posedge clock);
      #1;
      reset = 1'b0;
      run   = 1'b0;

      vecs = '{
         '{"idle",        0, 9'b000_000_000, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0)},
         '{"mvi_t0",      1, 9'b001_010_000, 0, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"mvi_t1",      0, 9'b001_010_000, 0, o(0, 1, 0, 8'h04, 0, 0, 0, 0, 1)},
         '{"mvi_back_t0", 0, 9'b001_010_000, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0)},
         '{"mv_t0",       1, 9'b000_001_101, 0, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"mv_t1",       0, 9'b000_001_101, 0, o(8'h20, 0, 0, 8'h02, 0, 0, 0, 0, 1)},
         '{"add_t0",      1, 9'b010_011_110, 0, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"add_t1",      0, 9'b010_011_110, 0, o(8'h08, 0, 0, 0, 0, 1, 0, 0, 0)},
         '{"add_t2",      0, 9'b010_011_110, 0, o(8'h40, 0, 0, 0, 0, 0, 1, 2'b00, 0)},
         '{"add_t3",      0, 9'b010_011_110, 0, o(0, 0, 1, 8'h08, 0, 0, 0, 0, 1)},
         '{"sub_t0",      1, 9'b011_011_110, 0, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"sub_t1",      0, 9'b011_011_110, 0, o(8'h08, 0, 0, 0, 0, 1, 0, 0, 0)},
         '{"sub_t2",      0, 9'b011_011_110, 0, o(8'h40, 0, 0, 0, 0, 0, 1, 2'b01, 0)},
         '{"sub_t3",      0, 9'b011_011_110, 0, o(0, 0, 1, 8'h08, 0, 0, 0, 0, 1)},
         '{"and_t0",      1, 9'b100_111_001, 0, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"and_t1",      0, 9'b100_111_001, 0, o(8'h80, 0, 0, 0, 0, 1, 0, 0, 0)},
         '{"and_t2",      0, 9'b100_111_001, 0, o(8'h02, 0, 0, 0, 0, 0, 1, 2'b10, 0)},
         '{"and_t3",      0, 9'b100_111_001, 0, o(0, 0, 1, 8'h80, 0, 0, 0, 0, 1)},
         '{"or_t0",       1, 9'b101_000_100, 0, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"or_t1",       0, 9'b101_000_100, 0, o(8'h01, 0, 0, 0, 0, 1, 0, 0, 0)},
         '{"or_t2",       0, 9'b101_000_100, 0, o(8'h10, 0, 0, 0, 0, 0, 1, 2'b11, 0)},
         '{"or_t3",       0, 9'b101_000_100, 0, o(0, 0, 1, 8'h01, 0, 0, 0, 0, 1)},
         '{"mvnz1_t0",    1, 9'b110_000_111, 1, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"mvnz1_t1",    0, 9'b110_000_111, 1, o(8'h80, 0, 0, 8'h01, 0, 0, 0, 0, 1)},
         '{"mvnz0_t0",    1, 9'b110_000_111, 0, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"mvnz0_t1",    0, 9'b110_000_111, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 1)},
         '{"nop_t0",      1, 9'b111_101_010, 1, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"nop_t1",      0, 9'b111_101_010, 1, o(0, 0, 0, 0, 0, 0, 0, 0, 1)},
         '{"mv33_t0",     1, 9'b000_011_011, 0, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"mv33_t1",     0, 9'b000_011_011, 0, o(8'h08, 0, 0, 8'h08, 0, 0, 0, 0, 1)},
         '{"add22_t0",    1, 9'b010_010_010, 0, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"add22_t1",    0, 9'b010_010_010, 0, o(8'h04, 0, 0, 0, 0, 1, 0, 0, 0)},
         '{"add22_t2",    0, 9'b010_010_010, 0, o(8'h04, 0, 0, 0, 0, 0, 1, 2'b00, 0)},
         '{"add22_t3",    0, 9'b010_010_010, 0, o(0, 0, 1, 8'h04, 0, 0, 0, 0, 1)},
         // run held high: mvi then add with no gap, run dropped in T2
         '{"b2b_mvi_t0",  1, 9'b001_010_000, 0, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"b2b_mvi_t1",  1, 9'b001_010_000, 0, o(0, 1, 0, 8'h04, 0, 0, 0, 0, 1)},
         '{"b2b_add_t0",  1, 9'b010_011_110, 0, o(0, 0, 0, 0, 1, 0, 0, 0, 0)},
         '{"b2b_add_t1",  1, 9'b010_011_110, 0, o(8'h08, 0, 0, 0, 0, 1, 0, 0, 0)},
         '{"b2b_add_t2",  0, 9'b010_011_110, 0, o(8'h40, 0, 0, 0, 0, 0, 1, 2'b00, 0)},
         '{"b2b_add_t3",  0, 9'b010_011_110, 0, o(0, 0, 1, 8'h08, 0, 0, 0, 0, 1)},
         '{"b2b_idle1",   0, 9'b010_011_110, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0)},
         '{"b2b_idle2",   0, 9'b010_011_110, 0, o(0, 0, 0, 0, 0, 0, 0, 0, 0)}
      };

      foreach (vecs[i]) begin
         step(vecs[i].run, vecs[i].ir, vecs[i].g_nz);
         check(vecs[i].name, vecs[i].exp);
      end

      // Reset during T2 of sub
      step(1, 9'b011_100_001, 0);
      check("rst_sub_t0", o(0, 0, 0, 0, 1, 0, 0, 0, 0));
      step(0, 9'b011_100_001, 0);
      check("rst_sub_t1", o(8'h10, 0, 0, 0, 0, 1, 0, 0, 0));
      step(0, 9'b011_100_001, 0);
      check("rst_sub_t2", o(8'h02, 0, 0, 0, 0, 0, 1, 2'b01, 0));
      #1;
      reset = 1'b1;
      #1;
      check("rst_mid_immediate", z);
      @(negedge clock);
      check("rst_mid_held", z);
      @(posedge clock);
      #1;
      reset = 1'b0;
      run   = 1'b0;
      @(negedge clock);
      check("rst_release_idle", z);
      step(0, 9'b011_100_001, 0);
      check("rst_release_idle2", z);
      step(1, 9'b001_110_000, 0);
      check("rst_restart_t0", o(0, 0, 0, 0, 1, 0, 0, 0, 0));
      step(0, 9'b001_110_000, 0);
      check("rst_restart_t1", o(0, 1, 0, 8'h40, 0, 0, 0, 0, 1));

      // Randomized run against the step-count model
      begin
         int         k = 0;
         int         len = 2;
         logic [8:0] cur = '0;
         logic       r, g, rs;
         outs_t      e;
         for (int n = 0; n < 600; n++) begin
            @(posedge clock);
            #1;
            if (k == 0) begin
               cur = 9'($urandom);
               len = (cur[8:6] >= 3'd2 && cur[8:6] <= 3'd5) ? 4 : 2;
            end
            r  = ($urandom_range(3) != 0);
            g  = 1'($urandom);
            rs = ($urandom_range(39) == 0);
            run   = r;
            ir    = cur;
            g_nz  = g;
            reset = rs;
            @(negedge clock);
            e = rs ? '0 : model(k, r, cur, g);
            check("random", e);
            if (rs) begin
               k = 0;
            end else if (k == 0) begin
               k = r ? 1 : 0;
            end else if (k + 1 < len) begin
               k = k + 1;
            end else begin
               k = 0;
            end
         end
         @(posedge clock);
         #1;
         reset = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
